// File: rtl/semi_auto.sv
// semi_auto: semi-automatic navigation controller.
// The controller drives the car along corridors. It turns by itself at dead
// ends and at single-exit corners. At junctions with a choice it stops and
// waits for a user command. Turns use a trigger/handshake with the turning
// unit through is_turning.
module semi_auto (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       is_turning,
    input  logic       move_forward,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_backward,
    input  logic [3:0] detector,
    output logic       out_move_forward,
    output logic       trigger_turn_left,
    output logic       trigger_turn_right,
    output logic       trigger_turn_back
);

    typedef enum logic [2:0] {
        ST_WAIT       = 3'd0,
        ST_MOVING     = 3'd1,
        ST_TURN_START = 3'd2,
        ST_TURN_END   = 3'd3,
        ST_LEAVE      = 3'd4
    } state_t;

    state_t state_q;
    logic   fwd_q;
    logic   trig_left_q;
    logic   trig_right_q;
    logic   trig_back_q;

    // Wall sensor decode. The back sensor is never consulted.
    logic wall_front;
    logic wall_left;
    logic wall_right;
    logic corridor;

    assign wall_front = detector[3];
    assign wall_left  = detector[1];
    assign wall_right = detector[0];
    assign corridor   = !wall_front && wall_left && wall_right;

    // Single FSM. Outputs are registered with the state. Triggers default
    // low, so every trigger lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q      <= ST_WAIT;
            fwd_q        <= 1'b0;
            trig_left_q  <= 1'b0;
            trig_right_q <= 1'b0;
            trig_back_q  <= 1'b0;
        end else begin
            trig_left_q  <= 1'b0;
            trig_right_q <= 1'b0;
            trig_back_q  <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    fwd_q <= 1'b0;
                    // Priority is forward > left > right > back. A command
                    // whose way is blocked falls through to the next one.
                    if (move_forward && !wall_front) begin
                        fwd_q   <= 1'b1;
                        state_q <= ST_LEAVE;
                    end else if (move_left && !wall_left) begin
                        trig_left_q <= 1'b1;
                        state_q     <= ST_TURN_START;
                    end else if (move_right && !wall_right) begin
                        trig_right_q <= 1'b1;
                        state_q      <= ST_TURN_START;
                    end else if (move_backward) begin
                        trig_back_q <= 1'b1;
                        state_q     <= ST_TURN_START;
                    end
                end
                ST_MOVING: begin
                    if (corridor) begin
                        fwd_q <= 1'b1;
                    end else if (wall_front && wall_left && wall_right) begin
                        fwd_q       <= 1'b0;
                        trig_back_q <= 1'b1;
                        state_q     <= ST_TURN_START;
                    end else if (wall_front && !wall_left && wall_right) begin
                        fwd_q       <= 1'b0;
                        trig_left_q <= 1'b1;
                        state_q     <= ST_TURN_START;
                    end else if (wall_front && wall_left && !wall_right) begin
                        fwd_q        <= 1'b0;
                        trig_right_q <= 1'b1;
                        state_q      <= ST_TURN_START;
                    end else begin
                        // The junction offers a choice, so hand over to the user.
                        fwd_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_TURN_START: begin
                    fwd_q <= 1'b0;
                    if (is_turning) begin
                        state_q <= ST_TURN_END;
                    end
                end
                ST_TURN_END: begin
                    fwd_q <= 1'b0;
                    if (!is_turning) begin
                        fwd_q   <= 1'b1;
                        state_q <= ST_LEAVE;
                    end
                end
                ST_LEAVE: begin
                    // Drive out of the junction without deciding anything.
                    fwd_q <= 1'b1;
                    if (corridor) begin
                        state_q <= ST_MOVING;
                    end
                end
                default: begin
                    fwd_q   <= 1'b0;
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign out_move_forward   = fwd_q;
    assign trigger_turn_left  = trig_left_q;
    assign trigger_turn_right = trig_right_q;
    assign trigger_turn_back  = trig_back_q;

endmodule

// File: tb/tb_semi_auto.sv
// tb_semi_auto: directed self-checking bench for semi_auto.
// Inputs change 1 time unit after a rising edge. Each check samples the
// outputs 1 time unit after the next rising edge. Expected values are
// written as {fwd, left, right, back}.
module tb_semi_auto;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       is_turning;
    logic       move_forward;
    logic       move_left;
    logic       move_right;
    logic       move_backward;
    logic [3:0] detector;
    logic       out_move_forward;
    logic       trigger_turn_left;
    logic       trigger_turn_right;
    logic       trigger_turn_back;

    int tests_run;
    int tests_failed;

    semi_auto dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .is_turning         (is_turning),
        .move_forward       (move_forward),
        .move_left          (move_left),
        .move_right         (move_right),
        .move_backward      (move_backward),
        .detector           (detector),
        .out_move_forward   (out_move_forward),
        .trigger_turn_left  (trigger_turn_left),
        .trigger_turn_right (trigger_turn_right),
        .trigger_turn_back  (trigger_turn_back)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge, then compare all four outputs against exp.
    task automatic step_check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        tick();
        obs = {out_move_forward, trigger_turn_left, trigger_turn_right, trigger_turn_back};
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed fwd/l/r/b=%b expected %b", tag, obs, exp);
        end
        $display("[TB] %-20s det=%b obs=%b exp=%b", tag, detector, obs, exp);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        enable = 1'b0;
        is_turning = 1'b0;
        move_forward = 1'b0;
        move_left = 1'b0;
        move_right = 1'b0;
        move_backward = 1'b0;
        detector = 4'b0011;
        tick();
        step_check("reset", 4'b0000);

        // The command is ignored while the controller is disabled.
        rst = 1'b0;
        move_forward = 1'b1;
        step_check("disable_0", 4'b0000);
        step_check("disable_1", 4'b0000);

        // Start forward in a corridor.
        enable = 1'b1;
        step_check("start_fwd", 4'b1000);
        move_forward = 1'b0;
        step_check("leave_to_moving", 4'b1000);
        step_check("moving_hold", 4'b1000);

        // Left corner is taken automatically.
        detector = 4'b1001;
        step_check("left_corner_trig", 4'b0100);
        step_check("trig_one_cycle", 4'b0000);
        is_turning = 1'b1;
        step_check("turn_start_wait", 4'b0000);
        is_turning = 1'b0;
        step_check("turn_end_fwd", 4'b1000);
        step_check("leave_hold", 4'b1000);
        detector = 4'b0011;
        step_check("back_to_moving", 4'b1000);

        // Dead end: is_turning is already high in the cycle after the trigger.
        detector = 4'b1011;
        step_check("dead_end_trig", 4'b0001);
        is_turning = 1'b1;
        step_check("dead_end_turning", 4'b0000);
        is_turning = 1'b0;
        step_check("dead_end_resume", 4'b1000);
        detector = 4'b0011;
        step_check("dead_end_moving", 4'b1000);

        // Junction: stop, the blocked right is ignored, left is accepted.
        detector = 4'b0001;
        step_check("junction_stop", 4'b0000);
        move_right = 1'b1;
        step_check("right_blocked", 4'b0000);
        move_left = 1'b1;
        step_check("left_cmd", 4'b0100);
        move_left = 1'b0;
        move_right = 1'b0;
        is_turning = 1'b1;
        step_check("left_turning", 4'b0000);
        is_turning = 1'b0;
        step_check("left_leave", 4'b1000);
        detector = 4'b0011;
        step_check("left_moving", 4'b1000);

        // Right corner, then disable in TURN_END.
        detector = 4'b1010;
        step_check("right_corner_trig", 4'b0010);
        is_turning = 1'b1;
        step_check("right_turning", 4'b0000);
        enable = 1'b0;
        step_check("disable_midturn", 4'b0000);
        enable = 1'b1;
        is_turning = 1'b0;
        step_check("reenable_idle_0", 4'b0000);
        step_check("reenable_idle_1", 4'b0000);

        // A right command in WAIT with only the right side open.
        detector = 4'b1000;
        move_right = 1'b1;
        step_check("wait_right_cmd", 4'b0010);
        move_right = 1'b0;
        is_turning = 1'b1;
        step_check("wait_right_turning", 4'b0000);
        rst = 1'b1;
        step_check("rst_midturn", 4'b0000);
        rst = 1'b0;
        is_turning = 1'b0;
        step_check("after_rst_idle", 4'b0000);

        // Blocked forward falls through to backward.
        move_forward = 1'b1;
        move_backward = 1'b1;
        step_check("fwd_blocked_back", 4'b0001);
        move_forward = 1'b0;
        move_backward = 1'b0;
        step_check("back_trig_ends", 4'b0000);

        // Forward wins over left when both are open.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        detector = 4'b0001;
        move_forward = 1'b1;
        move_left = 1'b1;
        step_check("fwd_over_left", 4'b1000);
        move_forward = 1'b0;
        move_left = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/semi_auto.md
# semi_auto

Semi-automatic navigation controller for the car simulation. It drives the car forward along corridors and turns automatically at dead-ends and single-exit corners. At junctions with more than one open way, it stops and waits for a direction command from the user. It sits between the user direction buttons / wall detectors and the turning unit: it issues turn triggers and waits for `is_turning` to handshake completion.

## Interface
No parameters.
- `clk` input 1 — system clock (500 Hz in the car top level); all logic on the rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `enable` input 1 — mode enable; low forces the idle state and all outputs low.
- `is_turning` input 1 — high while the turning unit is executing a turn.
- `move_forward` input 1 — user command, go straight; level, sampled only in WAIT.
- `move_left` input 1 — user command, turn left; level, sampled only in WAIT.
- `move_right` input 1 — user command, turn right; level, sampled only in WAIT.
- `move_backward` input 1 — user command, turn back; level, sampled only in WAIT.
- `detector` input 4 — wall sensors, 1 = wall present:
  - [3] front
  - [2] back
  - [1] left
  - [0] right
- `out_move_forward` output 1 — level; car drives forward while high.
- `trigger_turn_left` output 1 — one-cycle pulse requesting a left turn.
- `trigger_turn_right` output 1 — one-cycle pulse requesting a right turn.
- `trigger_turn_back` output 1 — one-cycle pulse requesting a U-turn.

## Operation
- All outputs are registered.
- **Corridor** means `detector[3]`=0, `[1]`=1, `[0]`=1; `detector[2]` is ignored everywhere.
- **WAIT** (reset/disable state; all outputs 0). Commands are accepted with priority forward > left > right > backward, and only when the way is open:
  - `move_forward` with front=0: set `out_move_forward`, go to LEAVE.
  - `move_left` with left=0: pulse `trigger_turn_left`, go to TURN_START.
  - `move_right` with right=0: pulse `trigger_turn_right`, go to TURN_START.
  - `move_backward`: always accepted; pulse `trigger_turn_back`, go to TURN_START.
  - A blocked command is ignored. Evaluation continues in the same cycle with the next lower-priority asserted command.
- **MOVING** (`out_move_forward`=1). Stay while the detector shows corridor. Otherwise, on the first non-corridor sample:
  - front=1, left=1, right=1: pulse `trigger_turn_back`, go to TURN_START.
  - front=1, left=0, right=1: pulse `trigger_turn_left`, go to TURN_START.
  - front=1, left=1, right=0: pulse `trigger_turn_right`, go to TURN_START.
  - Any other pattern (junction with a choice): clear `out_move_forward`, go to WAIT.
- **TURN_START** (`out_move_forward`=0). Wait for `is_turning`=1, then go to TURN_END. If `is_turning` is already 1 in the cycle after the trigger, advance immediately.
- **TURN_END**. Wait for `is_turning`=0, then set `out_move_forward`=1 and go to LEAVE.
- **LEAVE** (`out_move_forward`=1). Drive forward until the detector shows corridor, then go to MOVING. This is the exit from the junction; no decisions are made in LEAVE.
- Trigger outputs are exactly one cycle wide. At most one trigger is high in any cycle. `out_move_forward` is 0 in any cycle where a trigger is 1.
- `enable`=0 or `rst`=1 at any time:
  - the next edge forces WAIT with all outputs 0;
  - any in-progress turn handshake is abandoned;
  - `rst` has priority over `enable`.
- Re-enabling starts in WAIT; the car stays stopped until a user command is accepted.

## Timing
- State and outputs update on the rising edge after the sampled input condition. Latency from input change to output change is 1 cycle.
- Trigger pulse appears the cycle after the decision sample and lasts one cycle. The FSM reaches TURN_START on that same edge.
- After `is_turning` falls, `out_move_forward` rises 1 cycle later.
- MOVING re-evaluates `detector` every cycle. LEAVE → MOVING takes 1 cycle after the corridor is seen.
- No command buffering: a command pulse shorter than one clock, or one outside WAIT, is lost.

## Test plan
- **Disable:** `enable`=0, `move_forward` pulse → all outputs stay 0.
- **Start forward:** `enable`=1, detector=0011, `move_forward` pulse.
  - `out_move_forward`=1 one cycle later.
  - With detector held at 0011, it stays 1.
- **Auto left corner:** while MOVING, detector→1001.
  - One-cycle `trigger_turn_left`; `out_move_forward`=0.
  - `is_turning` 1 then 0 → `out_move_forward`=1 (LEAVE).
  - detector 0011 → MOVING.
- **Dead end:** while MOVING, detector→1011.
  - One-cycle `trigger_turn_back`.
  - After `is_turning` falls, forward resumes.
- **Junction wait and choice:** detector→0001 while MOVING → `out_move_forward`=0 (WAIT). Then:
  - `move_right` → no trigger (right blocked);
  - `move_left` → one-cycle `trigger_turn_left`, then handshake as above.
  - Also: detector 1000 with `move_right` → `trigger_turn_right`.
- **Reset/disable mid-turn:** `enable`=0 (or `rst`=1) in TURN_END → all outputs 0 next edge.
  - After re-enable, no output activity until a command arrives.
